css_mcu0_dmi_uncore_bridge: RTL and testbench

//  Terminates the uncore DMI aperture (0x50-0x7F) downstream of the MCU0 DMI mux.

---
 rtl/css_mcu0_dmi_pkg.sv | 30 +++
 rtl/css_mcu0_dmi_timeout_cnt.sv | 41 ++++
 rtl/css_mcu0_dmi_uncore_bridge.sv | 159 +++++++++++++++
 tb/tb_css_mcu0_dmi_uncore_bridge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/css_mcu0_dmi_pkg.sv
// Shared definitions for the MCU0 uncore DMI bridge: FSM states, local register map
// and status word layout.
package css_mcu0_dmi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [6:0] STATUS_ADDR_DEF = 7'h7F;
    localparam logic [6:0] RDATA_ADDR_DEF  = 7'h7E;

    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_ERR_BIT     = 1;
    localparam int unsigned STAT_TIMEOUT_BIT = 2;
    localparam int unsigned STAT_OVERRUN_BIT = 3;

    function automatic logic [31:0] pack_status(input logic busy, input logic err,
                                                input logic timeout, input logic overrun);
        logic [31:0] w;
        w                   = '0;
        w[STAT_BUSY_BIT]    = busy;
        w[STAT_ERR_BIT]     = err;
        w[STAT_TIMEOUT_BIT] = timeout;
        w[STAT_OVERRUN_BIT] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/css_mcu0_dmi_timeout_cnt.sv
// Transaction age counter: cleared at request launch, counts while enabled and
// flags expiry on the cycle its count reaches TIMEOUT_CYCLES.
module css_mcu0_dmi_timeout_cnt #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        // Saturate at the limit so a request accepted on its deadline still ages out.
        cnt_inc = (cnt_q == LIMIT) ? LIMIT : cnt_q + CNT_W'(1);
        cnt_d   = cnt_q;
        expire  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d  = cnt_inc;
            expire = (cnt_inc == LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/css_mcu0_dmi_uncore_bridge.sv
// Terminates the uncore DMI aperture: turns single-cycle DMI strobes into valid/ready
// bus requests, captures read data and keeps sticky error/timeout/overrun status.
module css_mcu0_dmi_uncore_bridge
    import css_mcu0_dmi_pkg::*;
#(
    parameter logic [6:0]  STATUS_ADDR    = STATUS_ADDR_DEF,
    parameter logic [6:0]  RDATA_ADDR     = RDATA_ADDR_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_uncore_en,
    input  logic        dmi_uncore_wr_en,
    input  logic [6:0]  dmi_uncore_addr,
    input  logic [31:0] dmi_uncore_wdata,
    output logic [31:0] dmi_uncore_rdata,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_write,
    output logic [6:0]  req_addr,
    output logic [31:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err
);

    state_e      state_q,     state_d;
    logic        req_write_q, req_write_d;
    logic [6:0]  req_addr_q,  req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [31:0] data_q,      data_d;
    logic [31:0] rdata_q,     rdata_d;
    // sticky_q: [0]=err, [1]=timeout, [2]=overrun (aligned with wdata[3:1] for W1C)
    logic [2:0]  sticky_q,    sticky_d;

    logic        busy;
    logic        is_local;
    logic        bus_en;
    logic        cnt_clear;
    logic        expire;
    logic        err_set;
    logic        to_set;
    logic        ov_set;
    logic [2:0]  w1c_mask;
    logic [31:0] status_word;

    css_mcu0_dmi_timeout_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (busy),
        .expire (expire)
    );

    assign busy        = (state_q != IDLE);
    assign is_local    = (dmi_uncore_addr == STATUS_ADDR) || (dmi_uncore_addr == RDATA_ADDR);
    assign bus_en      = dmi_uncore_en && !is_local;
    assign status_word = pack_status(busy, sticky_q[0], sticky_q[1], sticky_q[2]);

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        cnt_clear   = 1'b0;
        err_set     = 1'b0;
        to_set      = 1'b0;
        ov_set      = 1'b0;
        w1c_mask    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus_en) begin
                    req_write_d = dmi_uncore_wr_en;
                    req_addr_d  = dmi_uncore_addr;
                    req_wdata_d = dmi_uncore_wdata;
                    cnt_clear   = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_d = WAIT;
                end else if (expire) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                    data_d  = '0;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    state_d = IDLE;
                    err_set = rsp_err;
                    if (!req_write_q) begin
                        data_d  = rsp_rdata;
                        rdata_d = rsp_rdata;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    to_set  = 1'b1;
                    data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus_en && busy) begin
            ov_set = 1'b1;
        end

        // Local reads override a same-cycle response capture on the DMI return path.
        if (dmi_uncore_en && !dmi_uncore_wr_en) begin
            if (dmi_uncore_addr == STATUS_ADDR) begin
                rdata_d = status_word;
            end else if (dmi_uncore_addr == RDATA_ADDR) begin
                rdata_d = data_q;
            end
        end

        if (dmi_uncore_en && dmi_uncore_wr_en && (dmi_uncore_addr == STATUS_ADDR)) begin
            w1c_mask = dmi_uncore_wdata[3:1];
        end

        sticky_d = (sticky_q & ~w1c_mask) | {ov_set, to_set, err_set};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            data_q      <= '0;
            rdata_q     <= '0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            data_q      <= data_d;
            rdata_q     <= rdata_d;
            sticky_q    <= sticky_d;
        end
    end

    assign req_valid        = (state_q == REQ);
    assign req_write        = req_write_q;
    assign req_addr         = req_addr_q;
    assign req_wdata        = req_wdata_q;
    assign dmi_uncore_rdata = rdata_q;

endmodule

// File: tb/tb_css_mcu0_dmi_uncore_bridge.sv
// Self-checking bench for the uncore DMI bridge: randomized bus transactions checked
// against a transaction-level model of the sticky status, captured data and DMI read path.
module tb_css_mcu0_dmi_uncore_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmi_uncore_en;
    logic        dmi_uncore_wr_en;
    logic [6:0]  dmi_uncore_addr;
    logic [31:0] dmi_uncore_wdata;
    logic [31:0] dmi_uncore_rdata;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    css_mcu0_dmi_uncore_bridge #(
        .STATUS_ADDR    (7'h7F),
        .RDATA_ADDR     (7'h7E),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .dmi_uncore_en    (dmi_uncore_en),
        .dmi_uncore_wr_en (dmi_uncore_wr_en),
        .dmi_uncore_addr  (dmi_uncore_addr),
        .dmi_uncore_wdata (dmi_uncore_wdata),
        .dmi_uncore_rdata (dmi_uncore_rdata),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;

    // Reference model state
    logic        m_err, m_to, m_ov;
    logic [31:0] m_data;
    logic [31:0] m_rdata;

    function automatic logic [31:0] exp_status(input logic busy);
        return {28'b0, m_ov, m_to, m_err, busy};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic dmi(input logic wr, input logic [6:0] a, input logic [31:0] wd);
        dmi_uncore_en    = 1'b1;
        dmi_uncore_wr_en = wr;
        dmi_uncore_addr  = a;
        dmi_uncore_wdata = wd;
        step();
        dmi_uncore_en    = 1'b0;
        dmi_uncore_wr_en = 1'b0;
        dmi_uncore_addr  = '0;
        dmi_uncore_wdata = '0;
    endtask

    task automatic local_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
        dmi(1'b0, a, 32'h0);
        m_rdata = exp;
        chk(tag, dmi_uncore_rdata, m_rdata);
    endtask

    // One full bus transaction; d_ready + d_rsp must keep it within the timeout window.
    task automatic bus_txn(input logic wr, input logic [6:0] a, input logic [31:0] wd,
                           input int unsigned d_ready, input int unsigned d_rsp,
                           input logic [31:0] rd, input logic e);
        dmi(wr, a, wd);
        chk("req_valid_issue", 32'(req_valid), 32'h1);
        chk("req_addr_issue", 32'(req_addr), 32'(a));
        chk("req_write_issue", 32'(req_write), 32'(wr));
        chk("req_wdata_issue", req_wdata, wd);
        for (int i = 0; i < int'(d_ready); i++) begin
            step();
            chk("req_hold_valid", 32'(req_valid), 32'h1);
            chk("req_hold_addr", 32'(req_addr), 32'(a));
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("req_drop_after_ready", 32'(req_valid), 32'h0);
        repeat (d_rsp) step();
        rsp_valid = 1'b1;
        rsp_rdata = rd;
        rsp_err   = e;
        step();
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        m_err = m_err | e;
        if (!wr) begin
            m_data  = rd;
            m_rdata = rd;
        end
        chk(wr ? "rdata_after_write" : "rdata_after_read", dmi_uncore_rdata, m_rdata);
    endtask

    function automatic logic [6:0] rand_bus_addr();
        return 7'($urandom_range(32'h50, 32'h7D));
    endfunction

    initial begin
        logic [31:0] d;
        logic [6:0]  a;
        int unsigned n;

        rst = 1'b1;
        dmi_uncore_en = 1'b0; dmi_uncore_wr_en = 1'b0; dmi_uncore_addr = '0; dmi_uncore_wdata = '0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        m_err = 1'b0; m_to = 1'b0; m_ov = 1'b0; m_data = '0; m_rdata = '0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_req_addr", 32'(req_addr), 32'h0);
        chk("rst_req_wdata", req_wdata, 32'h0);
        chk("rst_rdata", dmi_uncore_rdata, 32'h0);
        local_rd("rst_status", 7'h7F, exp_status(1'b0));

        // Directed read: ready at once, response on the last cycle of the window
        bus_txn(1'b0, 7'h50, 32'h0, 0, 2, 32'hA5A5_0001, 1'b0);
        local_rd("status_after_read", 7'h7F, exp_status(1'b0));

        // Write with ready held off, status polled mid-request shows busy
        dmi(1'b1, 7'h60, 32'h1234);
        chk("wr_req_write", 32'(req_write), 32'h1);
        dmi(1'b0, 7'h7F, 32'h0);
        m_rdata = exp_status(1'b1);
        chk("status_busy", dmi_uncore_rdata, m_rdata);
        chk("wr_hold_wdata", req_wdata, 32'h1234);
        step();
        chk("wr_hold_addr", 32'(req_addr), 32'h60);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        step();
        rsp_valid = 1'b0;
        chk("wr_rdata_unchanged", dmi_uncore_rdata, m_rdata);
        local_rd("wr_data_q_unchanged", 7'h7E, m_data);

        // Randomized transactions, including handshakes on the deadline cycle
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 2);
            bus_txn(1'($urandom_range(0, 1)), rand_bus_addr(), $urandom,
                    n, $urandom_range(0, 2 - n), $urandom, 1'($urandom_range(0, 3) == 0));
            local_rd("rand_status", 7'h7F, exp_status(1'b0));
            local_rd("rand_data_q", 7'h7E, m_data);
        end

        // Clear everything, then timeout with ready never asserted
        dmi(1'b1, 7'h7F, 32'hE);
        m_err = 1'b0; m_to = 1'b0; m_ov = 1'b0;
        local_rd("status_cleared", 7'h7F, exp_status(1'b0));
        dmi(1'b0, rand_bus_addr(), 32'h0);
        n = 0;
        while (req_valid && n < 20) begin
            n++;
            step();
        end
        chk("timeout_req_cycles", n, TO);
        m_to = 1'b1;
        m_data = '0;
        repeat (2) step();
        rsp_valid = 1'b1;
        rsp_rdata = $urandom;
        step();
        rsp_valid = 1'b0;
        chk("late_rsp_ignored", dmi_uncore_rdata, m_rdata);
        local_rd("status_timeout", 7'h7F, exp_status(1'b0));
        local_rd("timeout_data_q", 7'h7E, 32'h0);
        dmi(1'b1, 7'h7E, 32'hFFFF_FFFF);
        local_rd("rdata_addr_write_ignored", 7'h7E, 32'h0);
        dmi(1'b1, 7'h7F, 32'h4);
        m_to = 1'b0;

        // Error response, W1C, and W1C racing a new error
        bus_txn(1'b0, rand_bus_addr(), 32'h0, 0, 0, $urandom, 1'b1);
        local_rd("status_err", 7'h7F, exp_status(1'b0));
        dmi(1'b1, 7'h7F, 32'h2);
        m_err = 1'b0;
        local_rd("status_err_w1c", 7'h7F, exp_status(1'b0));
        bus_txn(1'b0, rand_bus_addr(), 32'h0, 0, 0, $urandom, 1'b1);
        dmi(1'b0, rand_bus_addr(), 32'h0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        d = $urandom;
        dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b1; dmi_uncore_addr = 7'h7F; dmi_uncore_wdata = 32'h2;
        rsp_valid = 1'b1; rsp_rdata = d; rsp_err = 1'b1;
        step();
        dmi_uncore_en = 1'b0; dmi_uncore_wr_en = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        m_err = 1'b1;
        m_data = d; m_rdata = d;
        chk("w1c_race_rdata", dmi_uncore_rdata, m_rdata);
        local_rd("status_set_wins", 7'h7F, exp_status(1'b0));
        dmi(1'b1, 7'h7F, 32'hE);
        m_err = 1'b0;

        // Overrun: a second bus strobe while busy is dropped
        a = rand_bus_addr();
        dmi(1'b0, a, 32'h0);
        dmi(1'b1, 7'h51, 32'h5555);
        m_ov = 1'b1;
        chk("overrun_addr_kept", 32'(req_addr), 32'(a));
        chk("overrun_write_kept", 32'(req_write), 32'h0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        d = $urandom;
        rsp_valid = 1'b1; rsp_rdata = d;
        step();
        rsp_valid = 1'b0;
        m_data = d; m_rdata = d;
        chk("overrun_orig_completes", dmi_uncore_rdata, m_rdata);
        step();
        chk("overrun_no_second_req", 32'(req_valid), 32'h0);
        local_rd("status_overrun", 7'h7F, exp_status(1'b0));

        // Local read of RDATA_ADDR in the same cycle as a response capture
        dmi(1'b0, rand_bus_addr(), 32'h0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        d = $urandom;
        dmi_uncore_en = 1'b1; dmi_uncore_addr = 7'h7E;
        rsp_valid = 1'b1; rsp_rdata = d;
        step();
        dmi_uncore_en = 1'b0; rsp_valid = 1'b0;
        m_rdata = m_data;
        chk("local_read_wins", dmi_uncore_rdata, m_rdata);
        m_data = d;
        local_rd("data_q_captured", 7'h7E, m_data);

        // Reset while waiting for a response
        dmi(1'b0, rand_bus_addr(), 32'h0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_err = 1'b0; m_to = 1'b0; m_ov = 1'b0; m_data = '0; m_rdata = '0;
        chk("rst_wait_req_valid", 32'(req_valid), 32'h0);
        chk("rst_wait_rdata", dmi_uncore_rdata, 32'h0);
        local_rd("rst_wait_status", 7'h7F, exp_status(1'b0));
        bus_txn(1'b0, 7'h50, 32'h0, 1, 1, $urandom, 1'b0);
        local_rd("post_rst_status", 7'h7F, exp_status(1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
